switch_input_responder: RTL and testbench

Peripheral-side responder for the CPU's switch-input instruction. When the core raises an input request, the block stalls the core until the operator releases and then presses the Enter button. It then captures the 16 switches and returns them with a one-cycle acknowledge. It sits between the board I/O (raw button, switches) and the core's program-counter halt and input-source path.

---
 rtl/io_pkg.sv | 15 +
 rtl/input_debounce.sv | 52 +++++
 rtl/switch_input_responder.sv | 97 +++++++++
 tb/tb_switch_input_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the switch-input responder: FSM state encoding and default sizes.
package io_pkg;

    localparam int unsigned DefaultDataWidth      = 16;
    localparam int unsigned DefaultDebounceCycles = 4;

    typedef enum logic [2:0] {
        StIdle,
        StWaitRelease,
        StWaitPress,
        StAck,
        StDone
    } state_e;

endpackage

// File: rtl/input_debounce.sv
// Enter-button conditioning: 2-flop synchronizer, debounce counter, stable level and press strobe.
module input_debounce
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles
) (
    input  logic clock,
    input  logic n_reset,
    input  logic raw_n,
    output logic stable,
    output logic press
);

    localparam logic [7:0] LastCount = 8'(DEBOUNCE_CYCLES - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_stable;
    logic       r_press;
    logic [7:0] r_cnt;
    logic       w_accept;

    // Accept on the DEBOUNCE_CYCLES-th consecutive differing sample.
    assign w_accept = (r_sync2 != r_stable) && (r_cnt == LastCount);

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_stable <= 1'b1;
            r_press  <= 1'b0;
            r_cnt    <= 8'd0;
        end else begin
            r_sync1 <= raw_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= 8'd0;
            end else if (w_accept) begin
                r_stable <= r_sync2;
                r_cnt    <= 8'd0;
                r_press  <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign stable = r_stable;
    assign press  = r_press;

endmodule

// File: rtl/switch_input_responder.sv
// Stalls the core on an input request until a fresh debounced Enter press, then returns the
// synchronized switch value with a one-cycle acknowledge.
module switch_input_responder
    import io_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DefaultDataWidth,
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
    parameter int unsigned COUNT_WIDTH     = 8
) (
    input  logic                   clock,
    input  logic                   n_reset,
    input  logic                   button_n,
    input  logic [DATA_WIDTH-1:0]  switches,
    input  logic                   in_req,
    output logic                   in_ack,
    output logic [DATA_WIDTH-1:0]  in_data,
    output logic                   cpu_stall,
    output logic [COUNT_WIDTH-1:0] press_count
);

    state_e                 r_state;
    logic                   r_ack;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [DATA_WIDTH-1:0]  r_sw_sync1;
    logic [DATA_WIDTH-1:0]  r_sw_sync2;
    logic                   w_stable;
    logic                   w_press;

    input_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_input_debounce (
        .clock   (clock),
        .n_reset (n_reset),
        .raw_n   (button_n),
        .stable  (w_stable),
        .press   (w_press)
    );

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            r_sw_sync1 <= '0;
            r_sw_sync2 <= '0;
        end else begin
            r_sw_sync1 <= switches;
            r_sw_sync2 <= r_sw_sync1;
        end
    end

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            r_state <= StIdle;
            r_ack   <= 1'b0;
            r_data  <= '0;
            r_count <= '0;
        end else begin
            r_ack <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (in_req) r_state <= StWaitRelease;
                end
                // A button already held when the request arrives must be released first.
                StWaitRelease: begin
                    if (!in_req)      r_state <= StIdle;
                    else if (w_stable) r_state <= StWaitPress;
                end
                // Abort has priority over a coincident press event.
                StWaitPress: begin
                    if (!in_req) begin
                        r_state <= StIdle;
                    end else if (w_press) begin
                        r_data  <= r_sw_sync2;
                        r_count <= r_count + COUNT_WIDTH'(1);
                        r_ack   <= 1'b1;
                        r_state <= StAck;
                    end
                end
                StAck: begin
                    r_state <= StDone;
                end
                StDone: begin
                    if (!in_req) r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign cpu_stall   = in_req && ((r_state == StIdle) || (r_state == StWaitRelease) ||
                                    (r_state == StWaitPress));
    assign in_ack      = r_ack;
    assign in_data     = r_data;
    assign press_count = r_count;

endmodule

// File: tb/tb_switch_input_responder.sv
// Directed bench: stimulus pushes expected acknowledges into a queue that a negedge monitor checks.
module tb_switch_input_responder;

    logic        clock;
    logic        n_reset;
    logic        button_n;
    logic [15:0] switches;
    logic        in_req;
    logic        in_ack;
    logic [15:0] in_data;
    logic        cpu_stall;
    logic [7:0]  press_count;

    typedef struct {
        logic [15:0] data;
        logic [7:0]  count;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [7:0]  exp_count;
    logic [15:0] sw_val;

    switch_input_responder #(
        .DATA_WIDTH      (16),
        .DEBOUNCE_CYCLES (4),
        .COUNT_WIDTH     (8)
    ) dut (
        .clock       (clock),
        .n_reset     (n_reset),
        .button_n    (button_n),
        .switches    (switches),
        .in_req      (in_req),
        .in_ack      (in_ack),
        .in_data     (in_data),
        .cpu_stall   (cpu_stall),
        .press_count (press_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_exp(input logic [15:0] data, input logic [7:0] count, input int at);
        exp_t e;
        e.data  = data;
        e.count = count;
        e.cyc   = at;
        q.push_back(e);
    endtask

    always @(negedge clock) begin
        if (in_ack === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ack got in_data %h count %h expected no ack at cycle %0d",
                         in_data, press_count, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("ack_data", 32'(in_data), 32'(e.data));
                check("ack_count", 32'(press_count), 32'(e.count));
                check("ack_stall", 32'(cpu_stall), 32'd0);
                check("ack_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        n_reset  = 1'b0;
        button_n = 1'b1;
        switches = 16'hFFFF;
        in_req   = 1'b0;
        exp_count = 8'd0;
        ticks(3);
        check("rst_ack", 32'(in_ack), 32'd0);
        check("rst_data", 32'(in_data), 32'd0);
        check("rst_count", 32'(press_count), 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        n_reset = 1'b1;
        ticks(3);

        // Basic read: press at edge 0, ack visible after edge 7.
        switches = 16'h00A5;
        in_req   = 1'b1;
        ticks(3);
        check("basic_stall_wait", 32'(cpu_stall), 32'd1);
        exp_count = exp_count + 8'd1;
        push_exp(16'h00A5, exp_count, cyc + 7);
        button_n = 1'b0;
        ticks(6);
        check("basic_stall_pre_ack", 32'(cpu_stall), 32'd1);
        ticks(3);
        check("basic_stall_done", 32'(cpu_stall), 32'd0);
        in_req   = 1'b0;
        button_n = 1'b1;
        ticks(8);
        check("basic_count", 32'(press_count), 32'd1);

        // Button held when the request arrives.
        switches = 16'h1234;
        button_n = 1'b0;
        ticks(10);
        in_req = 1'b1;
        ticks(10);
        check("held_stall", 32'(cpu_stall), 32'd1);
        button_n = 1'b1;
        ticks(10);
        check("held_stall_released", 32'(cpu_stall), 32'd1);
        exp_count = exp_count + 8'd1;
        push_exp(16'h1234, exp_count, cyc + 7);
        button_n = 1'b0;
        ticks(10);
        in_req   = 1'b0;
        button_n = 1'b1;
        ticks(10);
        check("held_count", 32'(press_count), 32'd2);

        // Bounce: 3-cycle glitches rejected, then a real hold.
        switches = 16'hBEEF;
        in_req   = 1'b1;
        ticks(3);
        for (int k = 0; k < 3; k++) begin
            button_n = 1'b0;
            ticks(3);
            button_n = 1'b1;
            ticks(3);
        end
        check("bounce_stall", 32'(cpu_stall), 32'd1);
        check("bounce_count", 32'(press_count), 32'd2);
        exp_count = exp_count + 8'd1;
        push_exp(16'hBEEF, exp_count, cyc + 7);
        button_n = 1'b0;
        ticks(10);
        in_req   = 1'b0;
        button_n = 1'b1;
        ticks(10);
        check("bounce_count_after", 32'(press_count), 32'd3);

        // Abort on the same cycle the press event reaches the FSM.
        switches = 16'h5555;
        in_req   = 1'b1;
        ticks(3);
        button_n = 1'b0;
        ticks(6);
        in_req = 1'b0;
        ticks(2);
        check("abort_count", 32'(press_count), 32'd3);
        check("abort_data", 32'(in_data), 32'h0000BEEF);
        check("abort_stall", 32'(cpu_stall), 32'd0);
        in_req = 1'b1;
        ticks(4);
        check("abort_restall", 32'(cpu_stall), 32'd1);
        in_req   = 1'b0;
        button_n = 1'b1;
        ticks(10);

        // Wrap: 256 reads from a fresh reset bring the counter back to 0.
        n_reset = 1'b0;
        ticks(1);
        n_reset = 1'b1;
        ticks(2);
        exp_count = 8'd0;
        for (int i = 0; i < 256; i++) begin
            sw_val   = 16'(i) ^ 16'hA5A5;
            switches = sw_val;
            in_req   = 1'b1;
            ticks(3);
            exp_count = exp_count + 8'd1;
            push_exp(sw_val, exp_count, cyc + 7);
            button_n = 1'b0;
            ticks(9);
            in_req   = 1'b0;
            button_n = 1'b1;
            ticks(7);
        end
        check("wrap_count", 32'(press_count), 32'd0);

        // Reset while in DONE.
        switches = 16'h0F0F;
        in_req   = 1'b1;
        ticks(3);
        exp_count = exp_count + 8'd1;
        push_exp(16'h0F0F, exp_count, cyc + 7);
        button_n = 1'b0;
        ticks(10);
        check("done_stall", 32'(cpu_stall), 32'd0);
        check("done_data", 32'(in_data), 32'h00000F0F);
        n_reset = 1'b0;
        ticks(1);
        check("midrst_ack", 32'(in_ack), 32'd0);
        check("midrst_data", 32'(in_data), 32'd0);
        check("midrst_count", 32'(press_count), 32'd0);
        check("midrst_stall", 32'(cpu_stall), 32'd1);
        n_reset  = 1'b1;
        in_req   = 1'b0;
        button_n = 1'b1;
        ticks(10);
        check("queue_empty", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
